uart_mem_loader: RTL

- Receives the PC-to-FPGA UART byte stream and loads it into a word-organised RAM, either instruction or data memory.
- Sits between the UART receiver byte interface and the RAM write port. It is the upstream feeder of the memory-load path used during the instruction-load and data-load phases of the top-level sequence.
- Packs bytes little-endian into MEM_WORD_LENGTH-bit words, writes them sequentially from address 0 up to a programmable end address, then pulses done.
- Aborts a stalled transfer after an inter-byte timeout.

---
 rtl/loader_pkg.sv | 16 +
 rtl/loader_timeout_counter.sv | 26 ++
 rtl/uart_mem_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART-to-RAM load path.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

  function automatic int bytes_per_word(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, flags expiry.
// TIMEOUT_CYCLES = 0 never expires.
module loader_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rstN,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstN || i_clr) r_cnt <= '0;
    else if (i_en)      r_cnt <= r_cnt + 1'b1;
  end

  // Fires on the cycle whose edge would bring the count to TIMEOUT_CYCLES.
  assign o_expired = (TIMEOUT_CYCLES != 0) && i_en && !i_clr && (r_cnt >= LAST);

endmodule

// File: rtl/uart_mem_loader.sv
// Packs UART bytes little-endian into RAM words, writes addr 0..end_addr, pulses done.
// Define UART_MEM_LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter  int MEM_WORD_LENGTH = 12,
  parameter  int MEM_DEPTH       = 4096,
  parameter  int TIMEOUT_CYCLES  = 50_000_000,
  localparam int ADDR_WIDTH      = $clog2(MEM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      end_addr,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_in,
  output logic                       mem_wr_en,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [MEM_WORD_LENGTH-1:0] mem_data,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic                       chk_err
);

  localparam int            BPW      = bytes_per_word(MEM_WORD_LENGTH);
  localparam int            IW       = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

  loader_state_t              r_state;
  logic [IW-1:0]              r_idx;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [ADDR_WIDTH-1:0]      r_end;
  logic [BPW*8-1:0]           r_asm;
  logic [MEM_WORD_LENGTH-1:0] r_data;
  logic                       r_tmo_err;

  logic                       w_last_addr;
  logic                       w_take;
  logic                       w_word_done;
  logic [IW-1:0]              w_ins_idx;
  logic [BPW*8-1:0]           w_asm;
  logic                       w_tmo_en;
  logic                       w_tmo_clr;
  logic                       w_expired;
  logic                       w_tmo;

`ifdef UART_MEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_chk_err;
  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

  // A byte landing in a non-final WRITE cycle starts the next word at index 0.
  assign w_last_addr = (r_addr == r_end);
  assign w_take      = byte_valid &&
                       ((r_state == RECV) || ((r_state == WRITE) && !w_last_addr));
  assign w_ins_idx   = (r_state == WRITE) ? '0 : r_idx;
  assign w_word_done = w_take && (w_ins_idx == LAST_IDX);

  always_comb begin
    w_asm = r_asm;
    for (int k = 0; k < BPW; k++)
      if (w_ins_idx == IW'(k)) w_asm[8*k +: 8] = byte_in;
  end

  assign w_tmo_en  = (r_state == RECV) || (r_state == WRITE) || (r_state == CHECK);
  assign w_tmo_clr = !w_tmo_en || byte_valid;
  assign w_tmo     = w_expired && ((r_state == RECV) || (r_state == CHECK));

  loader_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .rstN     (rstN),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_addr    <= '0;
      r_end     <= '0;
      r_asm     <= '0;
      r_data    <= '0;
      r_tmo_err <= 1'b0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      r_sum     <= '0;
      r_chk_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_end     <= end_addr;
            r_addr    <= '0;
            r_idx     <= '0;
            r_tmo_err <= 1'b0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
            r_sum     <= '0;
            r_chk_err <= 1'b0;
`endif
            r_state   <= RECV;
          end
        end
        RECV: begin
          if (w_tmo) begin
            r_tmo_err <= 1'b1;
            r_state   <= IDLE;
          end
        end
        WRITE: begin
          if (w_last_addr) begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
            // A byte arriving in the final WRITE cycle is already the checksum.
            if (byte_valid) begin
              r_chk_err <= (byte_in != r_sum);
              r_state   <= DONE;
            end else begin
              r_state   <= CHECK;
            end
`else
            r_state <= DONE;
`endif
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_idx   <= '0;
            r_state <= RECV;
          end
        end
        CHECK: begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
          if (byte_valid) begin
            r_chk_err <= (byte_in != r_sum);
            r_state   <= DONE;
          end else if (w_tmo) begin
            r_tmo_err <= 1'b1;
            r_state   <= IDLE;
          end
`else
          r_state <= IDLE;
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Data byte capture overrides the per-state next-state above.
      if (w_take) begin
        r_asm <= w_asm;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        r_sum <= r_sum + byte_in;
`endif
        if (w_word_done) begin
          r_data  <= w_asm[MEM_WORD_LENGTH-1:0];
          r_state <= WRITE;
        end else begin
          r_idx   <= w_ins_idx + 1'b1;
          r_state <= RECV;
        end
      end
    end
  end

  assign mem_wr_en   = (r_state == WRITE);
  assign mem_addr    = r_addr;
  assign mem_data    = r_data;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign timeout_err = r_tmo_err;

endmodule
